// File: rtl/beam_trigger_conditioner.sv
// beam_trigger_conditioner
// Per-beam trigger conditioner in the ifclk domain. It turns transferred
// trigger levels into single-cycle accept pulses, applies a per-beam mask and
// a programmable holdoff, and keeps saturating accept scalers that are latched
// and cleared on latch_i.
// Optional feature: define BEAM_COND_DROP_COUNT_EN to build per-beam counters
// of edges rejected during holdoff. Without it, drop_o is tied to zero.
module beam_trigger_conditioner #(
    parameter int NBEAMS       = 2,
    parameter int HOLDOFF_BITS = 8,
    parameter int SCALER_BITS  = 16
) (
    input  logic                            ifclk,
    input  logic                            rst_i,
    input  logic [NBEAMS-1:0]               trig_i,
    input  logic [NBEAMS-1:0]               mask_i,
    input  logic [HOLDOFF_BITS-1:0]         holdoff_i,
    input  logic                            latch_i,
    output logic [NBEAMS-1:0]               trig_o,
    output logic                            any_trig_o,
    output logic [NBEAMS-1:0]               busy_o,
    output logic [NBEAMS*SCALER_BITS-1:0]   scal_o,
    output logic [NBEAMS*SCALER_BITS-1:0]   drop_o,
    output logic                            scal_valid_o
);

    typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

    localparam logic [HOLDOFF_BITS-1:0] CNT_ZERO  = {HOLDOFF_BITS{1'b0}};
    localparam logic [HOLDOFF_BITS-1:0] CNT_ONE   = HOLDOFF_BITS'(1);
    localparam logic [SCALER_BITS-1:0]  SCAL_ZERO = {SCALER_BITS{1'b0}};
    localparam logic [SCALER_BITS-1:0]  SCAL_ONE  = SCALER_BITS'(1);
    localparam logic [SCALER_BITS-1:0]  SCAL_MAX  = {SCALER_BITS{1'b1}};

    logic [NBEAMS-1:0] r_trig_q;
    logic [NBEAMS-1:0] w_edge;
    logic              r_scal_valid;

    // Previous trigger level; all-ones at reset so a level already high at release never fires.
    always_ff @(posedge ifclk) begin
        if (rst_i) begin
            r_trig_q <= {NBEAMS{1'b1}};
        end else begin
            r_trig_q <= trig_i;
        end
    end

    assign w_edge = trig_i & ~r_trig_q;

    // Scaler update strobe, one cycle after each latch command.
    always_ff @(posedge ifclk) begin
        if (rst_i) begin
            r_scal_valid <= 1'b0;
        end else begin
            r_scal_valid <= latch_i;
        end
    end

    assign scal_valid_o = r_scal_valid;
    assign any_trig_o   = |trig_o;

    for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
        state_t                  r_state;
        state_t                  w_state_nxt;
        logic [HOLDOFF_BITS-1:0] r_cnt;
        logic [HOLDOFF_BITS-1:0] w_cnt_nxt;
        logic                    w_acc_ev;
        logic                    r_trig;
        logic [SCALER_BITS-1:0]  r_acc;
        logic [SCALER_BITS-1:0]  r_scal;

        // Holdoff FSM state and countdown registers.
        always_ff @(posedge ifclk) begin
            if (rst_i) begin
                r_state <= ST_IDLE;
                r_cnt   <= CNT_ZERO;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // Next state: an accept loads the holdoff; HOLD counts down and leaves at one.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                ST_IDLE: begin
                    if (w_acc_ev) begin
                        w_cnt_nxt   = holdoff_i;
                        w_state_nxt = (holdoff_i != CNT_ZERO) ? ST_HOLD : ST_IDLE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end

        // Output decode: unmasked edges are accepted only while idle.
        always_comb begin
            w_acc_ev = 1'b0;
            case (r_state)
                ST_IDLE: w_acc_ev = w_edge[b] & ~mask_i[b];
                ST_HOLD: w_acc_ev = 1'b0;
                default: w_acc_ev = 1'b0;
            endcase
        end

        // Registered single-cycle accept pulse.
        always_ff @(posedge ifclk) begin
            if (rst_i) begin
                r_trig <= 1'b0;
            end else begin
                r_trig <= w_acc_ev;
            end
        end

        // Accept scaler: saturating; on latch it is copied out and restarts with this cycle's event.
        always_ff @(posedge ifclk) begin
            if (rst_i) begin
                r_acc  <= SCAL_ZERO;
                r_scal <= SCAL_ZERO;
            end else if (latch_i) begin
                r_scal <= r_acc;
                r_acc  <= {{(SCALER_BITS-1){1'b0}}, w_acc_ev};
            end else if (w_acc_ev && (r_acc != SCAL_MAX)) begin
                r_acc <= r_acc + SCAL_ONE;
            end
        end

        assign trig_o[b] = r_trig;
        assign busy_o[b] = (r_state == ST_HOLD);
        assign scal_o[b*SCALER_BITS +: SCALER_BITS] = r_scal;

`ifdef BEAM_COND_DROP_COUNT_EN
        logic                   w_drop_ev;
        logic [SCALER_BITS-1:0] r_drop;
        logic [SCALER_BITS-1:0] r_drop_lat;

        // Dropped-edge decode: unmasked edges arriving during holdoff.
        always_comb begin
            w_drop_ev = 1'b0;
            case (r_state)
                ST_IDLE: w_drop_ev = 1'b0;
                ST_HOLD: w_drop_ev = w_edge[b] & ~mask_i[b];
                default: w_drop_ev = 1'b0;
            endcase
        end

        // Dropped-edge scaler, same latch and saturation behaviour as the accept scaler.
        always_ff @(posedge ifclk) begin
            if (rst_i) begin
                r_drop     <= SCAL_ZERO;
                r_drop_lat <= SCAL_ZERO;
            end else if (latch_i) begin
                r_drop_lat <= r_drop;
                r_drop     <= {{(SCALER_BITS-1){1'b0}}, w_drop_ev};
            end else if (w_drop_ev && (r_drop != SCAL_MAX)) begin
                r_drop <= r_drop + SCAL_ONE;
            end
        end

        assign drop_o[b*SCALER_BITS +: SCALER_BITS] = r_drop_lat;
`endif
    end

`ifndef BEAM_COND_DROP_COUNT_EN
    assign drop_o = {(NBEAMS*SCALER_BITS){1'b0}};
`endif

endmodule
